// File: rtl/pipe_popcnt_acc.sv
// Two-stage popcount accumulator: counts ones per beat and sums them per frame.
// Define POPCNT_SAT_EN for a saturating accumulator with a sticky per-frame out_ovf.
module pipe_popcnt_acc #(
  parameter int unsigned N_IN  = 9,
  parameter int unsigned ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  in_bits,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf
);
  localparam int unsigned CW = $clog2(N_IN + 1);

  logic             stall;
  logic             s1_valid_q;
  logic             s1_last_q;
  logic [CW-1:0]    s1_cnt_q;
  logic [CW-1:0]    s1_cnt_d;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_next;
  logic [ACC_W-1:0] out_sum_q;
  logic             out_valid_q;

  assign stall     = out_valid_q && !out_ready;
  assign in_ready  = !stall;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;

  always_comb begin
    s1_cnt_d = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      s1_cnt_d = s1_cnt_d + CW'(in_bits[i]);
    end
  end

`ifdef POPCNT_SAT_EN
  logic [ACC_W:0] sum_wide;
  logic           ovf_add;
  logic           frame_ovf_q;
  logic           out_ovf_q;

  assign sum_wide = {1'b0, acc_q} + (ACC_W + 1)'(s1_cnt_q);
  assign ovf_add  = sum_wide[ACC_W];
  assign acc_next = ovf_add ? '1 : sum_wide[ACC_W-1:0];
  assign out_ovf  = out_ovf_q;

  // Sticky flag follows the same advance condition as acc and is handed off at frame close.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_ovf_q <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else if (!stall && s1_valid_q) begin
      if (s1_last_q) begin
        out_ovf_q   <= frame_ovf_q | ovf_add;
        frame_ovf_q <= 1'b0;
      end else begin
        frame_ovf_q <= frame_ovf_q | ovf_add;
      end
    end
  end
`else
  assign acc_next = acc_q + ACC_W'(s1_cnt_q);
  assign out_ovf  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_cnt_q    <= '0;
      s1_last_q   <= 1'b0;
      acc_q       <= '0;
      out_sum_q   <= '0;
      out_valid_q <= 1'b0;
    end else if (!stall) begin
      // in_ready is high whenever this branch runs, so in_valid alone marks acceptance.
      s1_valid_q <= in_valid;
      s1_cnt_q   <= s1_cnt_d;
      s1_last_q  <= in_last;
      if (s1_valid_q && s1_last_q) begin
        out_sum_q   <= acc_next;
        out_valid_q <= 1'b1;
        acc_q       <= '0;
      end else begin
        out_valid_q <= 1'b0;
        if (s1_valid_q) begin
          acc_q <= acc_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_popcnt_acc.sv
// Self-checking bench for pipe_popcnt_acc: frame-level reference model plus directed cases.
// Expected overflow behaviour follows POPCNT_SAT_EN when the bench is built with it.
module tb_pipe_popcnt_acc;
  localparam int unsigned N_IN  = 9;
  localparam int unsigned ACC_W = 16;
  localparam longint      MAXV  = (longint'(1) << ACC_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             in_valid, in_ready, in_last;
  logic [N_IN-1:0]  in_bits;
  logic             out_valid, out_ready, out_ovf;
  logic [ACC_W-1:0] out_sum;

  logic       in_valid4, in_ready4, in_last4, out_valid4, out_ready4, out_ovf4;
  logic [8:0] in_bits4;
  logic [3:0] out_sum4;

  pipe_popcnt_acc #(.N_IN(N_IN), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_bits(in_bits), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_ovf(out_ovf)
  );

  pipe_popcnt_acc #(.N_IN(9), .ACC_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_bits(in_bits4), .in_last(in_last4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_sum(out_sum4), .out_ovf(out_ovf4)
  );

  int unsigned total_cnt = 0;
  int unsigned pass_cnt  = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: per-frame totals of accepted beats, queued in completion order.
  longint m_acc = 0;
  bit     m_ovf = 1'b0;
  longint exp_sum_q[$];
  bit     exp_ovf_q[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_sum_q.delete();
      exp_ovf_q.delete();
      m_acc = 0;
      m_ovf = 1'b0;
    end else begin
      chk("in_ready_rule", in_ready, !(out_valid && !out_ready));
      if (out_valid && out_ready) begin
        if (exp_sum_q.size() == 0) begin
          chk("spurious_result", out_valid, 0);
        end else begin
          chk("model_sum", out_sum, exp_sum_q.pop_front());
          chk("model_ovf", out_ovf, exp_ovf_q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        m_acc = m_acc + $countones(in_bits);
        if (m_acc > MAXV) begin
`ifdef POPCNT_SAT_EN
          m_acc = MAXV;
          m_ovf = 1'b1;
`else
          m_acc = m_acc - (MAXV + 1);
`endif
        end
        if (in_last) begin
          exp_sum_q.push_back(m_acc);
          exp_ovf_q.push_back(m_ovf);
          m_acc = 0;
          m_ovf = 1'b0;
        end
      end
    end
  end

  // Present a beat and hold it until accepted; returns just after the accepting edge.
  task automatic send(input logic [N_IN-1:0] b, input logic l);
    int unsigned n = 0;
    in_valid = 1'b1;
    in_bits  = b;
    in_last  = l;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        chk("send_timeout", in_ready, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(input string name, input longint exp_sum);
    int unsigned n = 0;
    forever begin
      @(negedge clk);
      if (out_valid) begin
        chk(name, out_sum, exp_sum);
        break;
      end
      n++;
      if (n > 20) begin
        chk({name, "_timeout"}, out_valid, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned n;
    rst_n = 1'b1; in_valid = 1'b0; in_bits = '0; in_last = 1'b0; out_ready = 1'b1;
    in_valid4 = 1'b0; in_bits4 = '0; in_last4 = 1'b0; out_ready4 = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_ovf", out_ovf, 0);
    chk("rst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("in_ready_after_rst", in_ready, 1);

    // Single all-ones beat: two-register latency.
    send(9'h1FF, 1'b1);
    in_valid = 1'b0;
    @(negedge clk); chk("lat_stage1_valid", out_valid, 0);
    @(negedge clk); chk("lat_stage2_valid", out_valid, 1); chk("lat_sum", out_sum, 9);
    @(posedge clk); #1;

    // Three-beat frame then a fresh single-beat frame.
    send(9'h001, 1'b0);
    send(9'h0FF, 1'b0);
    send(9'h1FF, 1'b1);
    in_valid = 1'b0;
    wait_out("frame3_sum", 18);
    send(9'h003, 1'b1);
    in_valid = 1'b0;
    wait_out("next_frame_sum", 2);

    // All-zero single beat.
    send(9'h000, 1'b1);
    in_valid = 1'b0;
    wait_out("zeros_sum", 0);

    // Back-to-back single-beat frames.
    in_valid = 1'b1; in_bits = 9'h001; in_last = 1'b1;
    @(posedge clk); #1;
    in_bits = 9'h003;
    @(posedge clk); #1;
    in_bits = 9'h007;
    @(negedge clk); chk("b2b_v1", out_valid, 1); chk("b2b_s1", out_sum, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk); chk("b2b_v2", out_valid, 1); chk("b2b_s2", out_sum, 2);
    @(negedge clk); chk("b2b_v3", out_valid, 1); chk("b2b_s3", out_sum, 3);
    @(posedge clk); #1;

    // Stall with input streaming behind a held result.
    out_ready = 1'b0;
    send(9'h005, 1'b1);
    in_bits = 9'h0F0; in_last = 1'b1;
    @(posedge clk); #1;
    in_bits = 9'h111;
    repeat (5) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_valid", out_valid, 1);
      chk("stall_sum", out_sum, 2);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    #1 chk("release_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk); chk("release_v1", out_valid, 1); chk("release_s1", out_sum, 4);
    @(negedge clk); chk("release_v2", out_valid, 1); chk("release_s2", out_sum, 3);
    @(posedge clk); #1;

    // Reset in the middle of a frame.
    send(9'h0FF, 1'b0);
    send(9'h0FF, 1'b0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_sum", out_sum, 0);
    chk("midrst_ovf", out_ovf, 0);
    chk("midrst_in_ready", in_ready, 1);
    @(negedge clk); chk("midrst_valid_hold", out_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("postrst_in_ready", in_ready, 1);
    send(9'h00F, 1'b1);
    in_valid = 1'b0;
    wait_out("postrst_sum", 4);

    // Narrow accumulator overflow.
    in_valid4 = 1'b1; in_bits4 = 9'h1FF; in_last4 = 1'b0;
    @(negedge clk); chk("acc4_in_ready", in_ready4, 1);
    @(posedge clk); #1;
    in_last4 = 1'b1;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    n = 0;
    while (!out_valid4 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("acc4_valid", out_valid4, 1);
`ifdef POPCNT_SAT_EN
    chk("acc4_sum", out_sum4, 15);
    chk("acc4_ovf", out_ovf4, 1);
`else
    chk("acc4_sum", out_sum4, 2);
    chk("acc4_ovf", out_ovf4, 0);
`endif

    // Randomized traffic with random back-pressure.
    for (int i = 0; i < 3000; i++) begin
      int unsigned mode;
      mode      = $urandom_range(0, 9);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_bits   = N_IN'($urandom);
      if (mode == 0) in_bits = '1;
      if (mode == 1) in_bits = '0;
      in_last   = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end

    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (exp_sum_q.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_empty", exp_sum_q.size(), 0);
    @(posedge clk); #1;
    chk("idle_valid", out_valid, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
